// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control path: opcodes, FSM state
// encoding, datapath mux encodings and the one-hot instruction class type.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Encodings 13..15 are never entered; the FSM recovers from them via IDLE.
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_MEM_WB   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_EXEC     = 4'd7,
        ST_ALU_WB   = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_ADDI_EX  = 4'd10,
        ST_ADDI_WB  = 4'd11,
        ST_JUMP     = 4'd12
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic rtype;
        logic lw;
        logic sw;
        logic beq;
        logic addi;
        logic jump;
    } instr_class_t;

endpackage

// File: rtl/mc_opcode_decode.sv
// Combinational opcode classifier: turns the IR opcode field into a one-hot
// instruction class, honouring the optional ADDI/J support, and flags anything
// it does not recognise as illegal.
module mc_opcode_decode
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int ENABLE_ADDI = 1,
    parameter int ENABLE_JUMP = 1
) (
    input  logic [OPCODE_W-1:0] opcode,
    output instr_class_t        instr_class,
    output logic                illegal
);

    // Match each supported opcode; disabled optional opcodes fall through to illegal.
    always_comb begin
        instr_class       = '0;
        instr_class.rtype = (opcode == OPCODE_W'(OP_RTYPE));
        instr_class.lw    = (opcode == OPCODE_W'(OP_LW));
        instr_class.sw    = (opcode == OPCODE_W'(OP_SW));
        instr_class.beq   = (opcode == OPCODE_W'(OP_BEQ));
        instr_class.addi  = (ENABLE_ADDI != 0) && (opcode == OPCODE_W'(OP_ADDI));
        instr_class.jump  = (ENABLE_JUMP != 0) && (opcode == OPCODE_W'(OP_J));
        illegal           = (instr_class == '0);
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control: sequences each instruction through 3-5 states
// and drives the shared-datapath control lines, with a memory ready handshake,
// a fetch hold, an illegal-opcode pulse and a retired-instruction counter.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int ALUOP_W     = 2,
    parameter int ENABLE_ADDI = 1,
    parameter int ENABLE_JUMP = 1,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    input  logic                hold,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                RegWrite,
    output logic                RegDst,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          PCSource,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic                illegal_op,
    output logic [CNT_W-1:0]    retired,
    output logic [3:0]          state_o
);

    state_t       state;
    state_t       state_next;
    logic         retire_now;
    logic         is_load;
    instr_class_t dec_class;
    logic         dec_illegal;

    mc_opcode_decode #(
        .OPCODE_W    (OPCODE_W),
        .ENABLE_ADDI (ENABLE_ADDI),
        .ENABLE_JUMP (ENABLE_JUMP)
    ) u_decode (
        .opcode      (opcode),
        .instr_class (dec_class),
        .illegal     (dec_illegal)
    );

    // Next-state selection; retire_now marks the edge that leaves a final state.
    always_comb begin
        state_next = ST_IDLE;
        retire_now = 1'b0;
        case (state)
            ST_IDLE:     state_next = ST_FETCH;
            ST_FETCH:    state_next = (!hold && mem_ready) ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                if (dec_class.rtype)                  state_next = ST_EXEC;
                else if (dec_class.lw || dec_class.sw) state_next = ST_MEM_ADDR;
                else if (dec_class.beq)               state_next = ST_BRANCH;
                else if (dec_class.addi)              state_next = ST_ADDI_EX;
                else if (dec_class.jump)              state_next = ST_JUMP;
                else                                  state_next = ST_FETCH;
            end
            ST_MEM_ADDR: state_next = is_load ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   state_next = mem_ready ? ST_MEM_WB : ST_MEM_RD;
            ST_MEM_WR: begin
                state_next = mem_ready ? ST_FETCH : ST_MEM_WR;
                retire_now = mem_ready;
            end
            ST_EXEC:     state_next = ST_ALU_WB;
            ST_ADDI_EX:  state_next = ST_ADDI_WB;
            ST_MEM_WB, ST_ALU_WB, ST_BRANCH, ST_ADDI_WB, ST_JUMP: begin
                state_next = ST_FETCH;
                retire_now = 1'b1;
            end
            default:     state_next = ST_IDLE;
        endcase
    end

    // State register, load/store direction captured in DECODE, and retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            is_load <= 1'b0;
            retired <= '0;
        end else begin
            state <= state_next;
            if (state == ST_DECODE) begin
                is_load <= dec_class.lw;
            end
            if (retire_now) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    // Control lines decoded from the current state; fetch also looks at hold/mem_ready.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        PCSource    = PCSRC_ALU;
        ALUOp       = ALUOP_W'(ALUOP_ADD);
        illegal_op  = 1'b0;
        case (state)
            ST_FETCH: begin
                if (!hold) begin
                    MemRead = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
            end
            ST_DECODE: begin
                ALUSrcB    = SRCB_IMM_SH2;
                illegal_op = dec_illegal;
            end
            ST_MEM_ADDR, ST_ADDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            ST_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            ST_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            ST_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            ST_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_W'(ALUOP_FUNCT);
            end
            ST_ALU_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            ST_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_W'(ALUOP_SUB);
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
            end
            ST_ADDI_WB: RegWrite = 1'b1;
            ST_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            default: ;
        endcase
        state_o = state;
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a table of per-cycle vectors walks the default
// configuration through every instruction class, followed by hand-written
// sequences for async reset, disabled optional opcodes and counter wrap.
module tb_multicycle_control;

    localparam logic [5:0] O_R    = 6'b000000;
    localparam logic [5:0] O_LW   = 6'b100011;
    localparam logic [5:0] O_SW   = 6'b101011;
    localparam logic [5:0] O_BEQ  = 6'b000100;
    localparam logic [5:0] O_ADDI = 6'b001000;
    localparam logic [5:0] O_J    = 6'b000010;
    localparam logic [5:0] O_BAD  = 6'b111111;

    localparam logic [3:0] S_IDLE = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2, S_MADDR = 4'd3,
                           S_MRD  = 4'd4,  S_MWB   = 4'd5,  S_MWR    = 4'd6, S_EXEC  = 4'd7,
                           S_AWB  = 4'd8,  S_BR    = 4'd9,  S_AEX    = 4'd10, S_IWB  = 4'd11,
                           S_JUMP = 4'd12;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegWrite,RegDst,ALUSrcA,ALUSrcB,PCSource,ALUOp}
    localparam logic [15:0] C_ZERO   = 16'h0000;
    localparam logic [15:0] C_FWAIT  = 16'h1010;
    localparam logic [15:0] C_FDONE  = 16'h9410;
    localparam logic [15:0] C_DECODE = 16'h0030;
    localparam logic [15:0] C_MADDR  = 16'h0060;
    localparam logic [15:0] C_MRD    = 16'h3000;
    localparam logic [15:0] C_MWB    = 16'h0300;
    localparam logic [15:0] C_MWR    = 16'h2800;
    localparam logic [15:0] C_EXEC   = 16'h0042;
    localparam logic [15:0] C_AWB    = 16'h0180;
    localparam logic [15:0] C_BR     = 16'h4045;
    localparam logic [15:0] C_IWB    = 16'h0100;
    localparam logic [15:0] C_JUMP   = 16'h8008;

    typedef struct {
        logic [5:0]  opcode;
        logic        mem_ready;
        logic        hold;
        logic [3:0]  exp_state;
        logic [15:0] exp_ctrl;
        logic        exp_illegal;
        int          exp_retired;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       hold;

    always #5 clk = ~clk;

    // Default configuration
    logic        m_PCWrite, m_PCWriteCond, m_IorD, m_MemRead, m_MemWrite, m_IRWrite;
    logic        m_MemtoReg, m_RegWrite, m_RegDst, m_ALUSrcA, m_illegal;
    logic [1:0]  m_ALUSrcB, m_PCSource, m_ALUOp;
    logic [31:0] m_retired;
    logic [3:0]  m_state;
    logic [15:0] m_ctrl;

    assign m_ctrl = {m_PCWrite, m_PCWriteCond, m_IorD, m_MemRead, m_MemWrite, m_IRWrite,
                     m_MemtoReg, m_RegWrite, m_RegDst, m_ALUSrcA, m_ALUSrcB, m_PCSource, m_ALUOp};

    multicycle_control dut_main (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .hold(hold),
        .PCWrite(m_PCWrite), .PCWriteCond(m_PCWriteCond), .IorD(m_IorD), .MemRead(m_MemRead),
        .MemWrite(m_MemWrite), .IRWrite(m_IRWrite), .MemtoReg(m_MemtoReg), .RegWrite(m_RegWrite),
        .RegDst(m_RegDst), .ALUSrcA(m_ALUSrcA), .ALUSrcB(m_ALUSrcB), .PCSource(m_PCSource),
        .ALUOp(m_ALUOp), .illegal_op(m_illegal), .retired(m_retired), .state_o(m_state)
    );

    // Narrow counter, jump enabled
    logic        s_PCWrite, s_PCWriteCond, s_IorD, s_MemRead, s_MemWrite, s_IRWrite;
    logic        s_MemtoReg, s_RegWrite, s_RegDst, s_ALUSrcA, s_illegal;
    logic [1:0]  s_ALUSrcB, s_PCSource, s_ALUOp;
    logic [3:0]  s_retired;
    logic [3:0]  s_state;

    multicycle_control #(.CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .hold(hold),
        .PCWrite(s_PCWrite), .PCWriteCond(s_PCWriteCond), .IorD(s_IorD), .MemRead(s_MemRead),
        .MemWrite(s_MemWrite), .IRWrite(s_IRWrite), .MemtoReg(s_MemtoReg), .RegWrite(s_RegWrite),
        .RegDst(s_RegDst), .ALUSrcA(s_ALUSrcA), .ALUSrcB(s_ALUSrcB), .PCSource(s_PCSource),
        .ALUOp(s_ALUOp), .illegal_op(s_illegal), .retired(s_retired), .state_o(s_state)
    );

    // Optional opcodes disabled
    logic        n_PCWrite, n_PCWriteCond, n_IorD, n_MemRead, n_MemWrite, n_IRWrite;
    logic        n_MemtoReg, n_RegWrite, n_RegDst, n_ALUSrcA, n_illegal;
    logic [1:0]  n_ALUSrcB, n_PCSource, n_ALUOp;
    logic [31:0] n_retired;
    logic [3:0]  n_state;

    multicycle_control #(.ENABLE_ADDI(0), .ENABLE_JUMP(0)) dut_nojump (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .hold(hold),
        .PCWrite(n_PCWrite), .PCWriteCond(n_PCWriteCond), .IorD(n_IorD), .MemRead(n_MemRead),
        .MemWrite(n_MemWrite), .IRWrite(n_IRWrite), .MemtoReg(n_MemtoReg), .RegWrite(n_RegWrite),
        .RegDst(n_RegDst), .ALUSrcA(n_ALUSrcA), .ALUSrcB(n_ALUSrcB), .PCSource(n_PCSource),
        .ALUOp(n_ALUOp), .illegal_op(n_illegal), .retired(n_retired), .state_o(n_state)
    );

    task automatic addVec(input logic [5:0] op, input logic mr, input logic hd,
                          input logic [3:0] st, input logic [15:0] ctrl,
                          input logic ill, input int ret);
        vec_t v;
        v.opcode = op; v.mem_ready = mr; v.hold = hd;
        v.exp_state = st; v.exp_ctrl = ctrl; v.exp_illegal = ill; v.exp_retired = ret;
        vq.push_back(v);
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic mr, input logic hd);
        opcode = op; mem_ready = mr; hold = hd;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // R-type, all memory accesses ready immediately
        addVec(O_R,   1, 0, S_IDLE,   C_ZERO,   0, 0);
        addVec(O_R,   1, 0, S_FETCH,  C_FDONE,  0, 0);
        addVec(O_R,   1, 0, S_DECODE, C_DECODE, 0, 0);
        addVec(O_R,   1, 0, S_EXEC,   C_EXEC,   0, 0);
        addVec(O_R,   1, 0, S_AWB,    C_AWB,    0, 0);
        // LW with three wait cycles in MEM_RD: eight cycles total
        addVec(O_LW,  1, 0, S_FETCH,  C_FDONE,  0, 1);
        addVec(O_LW,  1, 0, S_DECODE, C_DECODE, 0, 1);
        addVec(O_LW,  0, 0, S_MADDR,  C_MADDR,  0, 1);
        addVec(O_LW,  0, 0, S_MRD,    C_MRD,    0, 1);
        addVec(O_LW,  0, 0, S_MRD,    C_MRD,    0, 1);
        addVec(O_LW,  0, 0, S_MRD,    C_MRD,    0, 1);
        addVec(O_LW,  1, 0, S_MRD,    C_MRD,    0, 1);
        addVec(O_LW,  0, 0, S_MWB,    C_MWB,    0, 1);
        // SW with a fetch wait and a write wait
        addVec(O_SW,  0, 0, S_FETCH,  C_FWAIT,  0, 2);
        addVec(O_SW,  1, 0, S_FETCH,  C_FDONE,  0, 2);
        addVec(O_SW,  1, 0, S_DECODE, C_DECODE, 0, 2);
        addVec(O_SW,  1, 0, S_MADDR,  C_MADDR,  0, 2);
        addVec(O_SW,  0, 0, S_MWR,    C_MWR,    0, 2);
        addVec(O_SW,  1, 0, S_MWR,    C_MWR,    0, 2);
        // BEQ
        addVec(O_BEQ, 1, 0, S_FETCH,  C_FDONE,  0, 3);
        addVec(O_BEQ, 1, 0, S_DECODE, C_DECODE, 0, 3);
        addVec(O_BEQ, 1, 0, S_BR,     C_BR,     0, 3);
        // ADDI
        addVec(O_ADDI,1, 0, S_FETCH,  C_FDONE,  0, 4);
        addVec(O_ADDI,1, 0, S_DECODE, C_DECODE, 0, 4);
        addVec(O_ADDI,1, 0, S_AEX,    C_MADDR,  0, 4);
        addVec(O_ADDI,1, 0, S_IWB,    C_IWB,    0, 4);
        // J
        addVec(O_J,   1, 0, S_FETCH,  C_FDONE,  0, 5);
        addVec(O_J,   1, 0, S_DECODE, C_DECODE, 0, 5);
        addVec(O_J,   1, 0, S_JUMP,   C_JUMP,   0, 5);
        // Illegal opcode: one-cycle pulse, back to FETCH, no retire
        addVec(O_BAD, 1, 0, S_FETCH,  C_FDONE,  0, 6);
        addVec(O_BAD, 1, 0, S_DECODE, C_DECODE, 1, 6);
        addVec(O_BAD, 0, 0, S_FETCH,  C_FWAIT,  0, 6);
        // hold for five cycles in FETCH, mem_ready must be ignored
        for (int i = 0; i < 5; i++) addVec(O_R, 1, 1, S_FETCH, C_ZERO, 0, 6);
        addVec(O_R,   0, 0, S_FETCH,  C_FWAIT,  0, 6);
        addVec(O_R,   1, 0, S_FETCH,  C_FDONE,  0, 6);
        addVec(O_R,   1, 0, S_DECODE, C_DECODE, 0, 6);
        addVec(O_R,   1, 0, S_EXEC,   C_EXEC,   0, 6);
        addVec(O_R,   0, 0, S_AWB,    C_AWB,    0, 6);
        addVec(O_R,   0, 0, S_FETCH,  C_FWAIT,  0, 7);

        // Reset state while rst_n is held low
        rst_n = 1'b0;
        applyStimulus(O_R, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("reset_state", 32'(m_state), 32'(S_IDLE));
        checkOutput("reset_ctrl", 32'(m_ctrl), 32'(C_ZERO));
        checkOutput("reset_retired", m_retired, 32'd0);
        checkOutput("reset_illegal", 32'(m_illegal), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (vq[i]) begin
            applyStimulus(vq[i].opcode, vq[i].mem_ready, vq[i].hold);
            @(negedge clk);
            checkOutput($sformatf("v%0d_state", i), 32'(m_state), 32'(vq[i].exp_state));
            checkOutput($sformatf("v%0d_ctrl", i), 32'(m_ctrl), 32'(vq[i].exp_ctrl));
            checkOutput($sformatf("v%0d_illegal", i), 32'(m_illegal), 32'(vq[i].exp_illegal));
            checkOutput($sformatf("v%0d_retired", i), m_retired, 32'(vq[i].exp_retired));
            tick();
        end

        // Async reset in the middle of a store
        applyStimulus(O_SW, 1'b1, 1'b0);
        tick();
        tick();
        applyStimulus(O_SW, 1'b0, 1'b0);
        tick();
        @(negedge clk);
        checkOutput("sw_before_rst_state", 32'(m_state), 32'(S_MWR));
        checkOutput("sw_before_rst_memwrite", 32'(m_MemWrite), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_memwrite", 32'(m_MemWrite), 32'd0);
        checkOutput("async_rst_ctrl", 32'(m_ctrl), 32'(C_ZERO));
        checkOutput("async_rst_state", 32'(m_state), 32'(S_IDLE));
        checkOutput("async_rst_retired", m_retired, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_idle", 32'(m_state), 32'(S_IDLE));
        tick();
        @(negedge clk);
        checkOutput("post_rst_fetch", 32'(m_state), 32'(S_FETCH));
        checkOutput("post_rst_fetch_ctrl", 32'(m_ctrl), 32'(C_FWAIT));
        checkOutput("post_rst_retired", m_retired, 32'd0);

        // Disabled J and ADDI decode as illegal
        doReset();
        applyStimulus(O_J, 1'b1, 1'b0);
        tick();
        tick();
        @(negedge clk);
        checkOutput("nj_j_state", 32'(n_state), 32'(S_DECODE));
        checkOutput("nj_j_illegal", 32'(n_illegal), 32'd1);
        checkOutput("main_j_legal", 32'(m_illegal), 32'd0);
        applyStimulus(O_ADDI, 1'b1, 1'b0);
        tick();
        @(negedge clk);
        checkOutput("nj_after_state", 32'(n_state), 32'(S_FETCH));
        checkOutput("nj_after_illegal", 32'(n_illegal), 32'd0);
        tick();
        @(negedge clk);
        checkOutput("nj_addi_illegal", 32'(n_illegal), 32'd1);
        tick();
        @(negedge clk);
        checkOutput("nj_retired", n_retired, 32'd0);

        // 16 back-to-back jumps wrap the 4-bit counter
        doReset();
        applyStimulus(O_J, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checkOutput($sformatf("wrap%0d_retired", i), 32'(s_retired), 32'(i));
            tick();
            tick();
            @(negedge clk);
            checkOutput($sformatf("wrap%0d_jump_state", i), 32'(s_state), 32'(S_JUMP));
            checkOutput($sformatf("wrap%0d_pcwrite", i), 32'(s_PCWrite), 32'd1);
            checkOutput($sformatf("wrap%0d_pcsource", i), 32'(s_PCSource), 32'd2);
            tick();
        end
        @(negedge clk);
        checkOutput("wrap_final_retired", 32'(s_retired), 32'd0);
        checkOutput("wrap_final_state", 32'(s_state), 32'(S_FETCH));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
